// File: rtl/pipeline_acc_pkg.sv
// Shared definitions for the pipeline_acc accumulate path: sequencer state
// encoding and the pipeline latencies that sum_ram and its controller must
// agree on.
package pipeline_acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GAP   = 3'd3,
        ST_RD    = 3'd4,
        ST_DONE  = 3'd5
    } acc_state_e;

    // dv_pre4 beat to RAM write
    localparam int C_WR_DLY_DEF = 7;
    // dv_pre4 beat to adder stage (first_flag sample point)
    localparam int C_FF_DLY_DEF = 4;
    // raddr to valid read data
    localparam int C_RD_LAT_DEF = 2;
    // width of the shared drain / read-wait counter
    localparam int C_CNT_W      = 4;

    // True in every state that belongs to a running job (DONE excluded).
    function automatic logic state_is_busy(input acc_state_e st);
        logic busy;
        case (st)
            ST_ACC, ST_DRAIN, ST_GAP, ST_RD: busy = 1'b1;
            default:                         busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/sum_ram_ctrl_if.sv
// Stream-in handshake plus the sum_ram control/readout bundle driven by the
// sum_ram_ctrl sequencer. master = controller side, slave = source/RAM side.
interface sum_ram_ctrl_if #(
    parameter int C_ASIZE = 10
);
    logic               src_valid;
    logic               src_ready;
    logic               dven;
    logic               dv_pre4;
    logic               first_flag;
    logic [C_ASIZE-1:0] raddr;
    logic               rd_valid;

    modport master (
        input  src_valid,
        output src_ready,
        output dven,
        output dv_pre4,
        output first_flag,
        output raddr,
        output rd_valid
    );

    modport slave (
        output src_valid,
        input  src_ready,
        input  dven,
        input  dv_pre4,
        input  first_flag,
        input  raddr,
        input  rd_valid
    );
endinterface

// File: rtl/dly.sv
// Fixed-latency delay line: C_DEPTH register stages of C_WIDTH bits,
// advancing every cycle, cleared by synchronous reset.
module dly #(
    parameter int C_WIDTH = 1,
    parameter int C_DEPTH = 1
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [C_WIDTH-1:0] I_din,
    output logic [C_WIDTH-1:0] O_dout
);

    logic [C_WIDTH-1:0] sr_q [C_DEPTH];
    logic [C_WIDTH-1:0] sr_d [C_DEPTH];

    // Next shift-register contents: new sample enters stage 0, others move up.
    always_comb begin
        sr_d[0] = I_din;
        for (int i = 1; i < C_DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    assign O_dout = sr_q[C_DEPTH-1];

endmodule

// File: rtl/sum_ram_ctrl.sv
// sum_ram_ctrl: sequencer for the pipelined accumulate RAM (sum_ram).
// Runs pass_num accumulation passes over pix_num pixels, drains the write
// pipeline after each pass, then reads the finished sums out.
// Optional build macro SUM_RAM_CTRL_STAT_EN adds O_stall_cnt (ACC cycles
// with no upstream beat available).
module sum_ram_ctrl
    import pipeline_acc_pkg::*;
#(
    parameter int C_ASIZE  = 10,
    parameter int C_PSIZE  = 8,
    parameter int C_WR_DLY = C_WR_DLY_DEF,
    parameter int C_FF_DLY = C_FF_DLY_DEF,
    parameter int C_RD_LAT = C_RD_LAT_DEF
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic [C_ASIZE:0]   I_pix_num,
    input  logic [C_PSIZE-1:0] I_pass_num,
    sum_ram_ctrl_if.master     bus,
`ifdef SUM_RAM_CTRL_STAT_EN
    output logic [31:0]        O_stall_cnt,
`endif
    output logic               O_busy,
    output logic               O_done
);

    localparam int C_PW = C_ASIZE + 1;

    acc_state_e         state_q, state_d;
    logic [C_PW-1:0]    pix_num_q, pix_num_d;
    logic [C_PSIZE-1:0] pass_num_q, pass_num_d;
    logic [C_PW-1:0]    pix_cnt_q, pix_cnt_d;
    logic [C_PSIZE-1:0] pass_cnt_q, pass_cnt_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [C_PW-1:0]    rd_cnt_q, rd_cnt_d;
    logic               ff_hold_q, ff_hold_d;
`ifdef SUM_RAM_CTRL_STAT_EN
    logic [31:0]        stall_q, stall_d;
`endif

    logic               src_ready_s;
    logic               dven_s;
    logic               beat_s;
    logic               tag_s;
    logic               rd_issue_s;
    logic [C_ASIZE-1:0] raddr_s;
    logic               busy_s;
    logic               done_s;
    logic [1:0]         ff_dly_s;
    logic               rd_valid_s;
    logic               first_flag_s;

    // A beat is any ACC cycle where upstream has data; it is combinational
    // so sum_ram sees dv_pre4 in the same cycle the source is consumed.
    assign beat_s = bus.src_valid & src_ready_s;

    // State and counter registers, synchronous reset to IDLE / zero.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            pix_num_q  <= '0;
            pass_num_q <= '0;
            pix_cnt_q  <= '0;
            pass_cnt_q <= '0;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            ff_hold_q  <= 1'b0;
`ifdef SUM_RAM_CTRL_STAT_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pix_num_q  <= pix_num_d;
            pass_num_q <= pass_num_d;
            pix_cnt_q  <= pix_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            ff_hold_q  <= ff_hold_d;
`ifdef SUM_RAM_CTRL_STAT_EN
            stall_q    <= stall_d;
`endif
        end
    end

    // Next-state and counter update logic for the pass/drain/readout sequence.
    always_comb begin
        state_d    = state_q;
        pix_num_d  = pix_num_q;
        pass_num_d = pass_num_q;
        pix_cnt_d  = pix_cnt_q;
        pass_cnt_d = pass_cnt_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (I_start) begin
                    if ((I_pix_num == '0) || (I_pass_num == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        pix_num_d  = I_pix_num;
                        pass_num_d = I_pass_num;
                        pix_cnt_d  = '0;
                        pass_cnt_d = '0;
                        state_d    = ST_ACC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (beat_s) begin
                    pix_cnt_d = pix_cnt_q + C_PW'(1);
                    if (pix_cnt_q == (pix_num_q - C_PW'(1))) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DRAIN: begin
                // Keep dven up until the last beat's write has landed.
                if (cnt_q == C_CNT_W'(C_WR_DLY)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_GAP: begin
                pass_cnt_d = pass_cnt_q + C_PSIZE'(1);
                if (pass_cnt_q == (pass_num_q - C_PSIZE'(1))) begin
                    rd_cnt_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RD;
                end else begin
                    pix_cnt_d = '0;
                    state_d   = ST_ACC;
                end
            end
            ST_RD: begin
                if (rd_cnt_q != pix_num_q) begin
                    rd_cnt_d = rd_cnt_q + C_PW'(1);
                end else if (cnt_q == C_CNT_W'(C_RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        src_ready_s = 1'b0;
        dven_s      = 1'b0;
        rd_issue_s  = 1'b0;
        raddr_s     = '0;
        done_s      = 1'b0;
        case (state_q)
            ST_ACC: begin
                src_ready_s = 1'b1;
                dven_s      = 1'b1;
            end
            ST_DRAIN: begin
                dven_s = 1'b1;
            end
            ST_RD: begin
                if (rd_cnt_q != pix_num_q) begin
                    rd_issue_s = 1'b1;
                    raddr_s    = rd_cnt_q[C_ASIZE-1:0];
                end else begin
                    rd_issue_s = 1'b0;
                    raddr_s    = '0;
                end
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
        busy_s = state_is_busy(state_q);
        tag_s  = (pass_cnt_q == '0);
    end

    // first_flag: the tag of the beat reaching the adder stage this cycle,
    // otherwise the tag of the most recent beat that got there.
    always_comb begin
        if (ff_dly_s[1]) begin
            first_flag_s = ff_dly_s[0];
            ff_hold_d    = ff_dly_s[0];
        end else begin
            first_flag_s = ff_hold_q;
            ff_hold_d    = ff_hold_q;
        end
    end

`ifdef SUM_RAM_CTRL_STAT_EN
    // Stall statistics: cleared when a job is started, saturating count of
    // ACC cycles without upstream data, frozen outside ACC.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && I_start) begin
            stall_d = '0;
        end else if ((state_q == ST_ACC) && !bus.src_valid && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    assign O_stall_cnt = stall_q;
`endif

    dly #(
        .C_WIDTH (2),
        .C_DEPTH (C_FF_DLY)
    ) u_ff_dly (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_din  ({beat_s, tag_s}),
        .O_dout (ff_dly_s)
    );

    dly #(
        .C_WIDTH (1),
        .C_DEPTH (C_RD_LAT)
    ) u_rd_dly (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_din  (rd_issue_s),
        .O_dout (rd_valid_s)
    );

    assign bus.src_ready  = src_ready_s;
    assign bus.dven       = dven_s;
    assign bus.dv_pre4    = beat_s;
    assign bus.first_flag = first_flag_s;
    assign bus.raddr      = raddr_s;
    assign bus.rd_valid   = rd_valid_s;
    assign O_busy         = busy_s;
    assign O_done         = done_s;

endmodule

// File: tb/tb_sum_ram_ctrl.sv
// Self-checking bench for sum_ram_ctrl. The expected timeline of each job is
// derived from pass/beat timestamps: a pass ends on its pix_num-th accepted
// beat, dven stays up 8 more cycles, one dven-low gap follows, and after the
// last gap pix_num reads are issued with data valid 2 cycles later.
module tb_sum_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] pix_num;
    logic [7:0]  pass_num;
    logic        busy;
    logic        done;
`ifdef SUM_RAM_CTRL_STAT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit ff_hold = 1'b0;

    always #5 clk = ~clk;

    sum_ram_ctrl_if #(.C_ASIZE(10)) bus ();

    sum_ram_ctrl dut (
        .I_clk      (clk),
        .I_rst      (rst),
        .I_start    (start),
        .I_pix_num  (pix_num),
        .I_pass_num (pass_num),
        .bus        (bus),
`ifdef SUM_RAM_CTRL_STAT_EN
        .O_stall_cnt(stall_cnt),
`endif
        .O_busy     (busy),
        .O_done     (done)
    );

    // Runs one job and checks every output each cycle against the timeline.
    task automatic run_job(input int pix, input int pass, input int vmode,
                           input bit poke, input int abort_pass, input string tag);
        int c, p, b, acc_start, last_beat, rd_start, done_at, budget, stall_exp;
        bit complete, trivial, finished, aborted, v;
        bit in_acc, exp_dven, exp_issue, exp_rv, exp_done, exp_busy, exp_ff;
        bit ff_v [int];
        bit ff_t [int];
        trivial = (pix == 0) || (pass == 0);
        @(posedge clk); #1;
        start = 1'b1; pix_num = 11'(pix); pass_num = 8'(pass);
        @(posedge clk); #1;
        start = 1'b0;
        p = 0; b = 0; acc_start = 0; last_beat = -100; rd_start = -1;
        done_at = trivial ? 0 : -1; stall_exp = 0;
        complete = 1'b0; finished = 1'b0; aborted = 1'b0;
        budget = pix * pass * 4 + pass * 16 + pix + 40;
        for (c = 0; c < budget && !finished; c++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.src_valid = v;
            if (poke && c == 3) begin
                start = 1'b1; pix_num = 11'(pix + 1); pass_num = 8'(pass + 1);
            end else begin
                start = 1'b0;
            end
            in_acc    = !trivial && rd_start < 0 && !complete && c >= acc_start;
            exp_dven  = in_acc || (!trivial && complete && c <= last_beat + 8);
            exp_issue = rd_start >= 0 && c >= rd_start && c < rd_start + pix;
            exp_rv    = rd_start >= 0 && c >= rd_start + 2 && c < rd_start + pix + 2;
            exp_done  = (c == done_at);
            exp_busy  = !trivial && (done_at < 0 || c < done_at);
            exp_ff    = ff_v.exists(c) ? ff_t[c] : ff_hold;
            ff_hold   = exp_ff;
            @(negedge clk);
            n_cmp++; if (bus.src_ready !== in_acc) begin n_bad++; if (n_bad <= 40) $display("FAIL %s src_ready c=%0d got=%b exp=%b", tag, c, bus.src_ready, in_acc); end
            n_cmp++; if (bus.dv_pre4 !== (v & in_acc)) begin n_bad++; if (n_bad <= 40) $display("FAIL %s dv_pre4 c=%0d got=%b exp=%b", tag, c, bus.dv_pre4, v & in_acc); end
            n_cmp++; if (bus.dven !== exp_dven) begin n_bad++; if (n_bad <= 40) $display("FAIL %s dven c=%0d got=%b exp=%b", tag, c, bus.dven, exp_dven); end
            n_cmp++; if (bus.first_flag !== exp_ff) begin n_bad++; if (n_bad <= 40) $display("FAIL %s first_flag c=%0d got=%b exp=%b", tag, c, bus.first_flag, exp_ff); end
            n_cmp++; if (bus.rd_valid !== exp_rv) begin n_bad++; if (n_bad <= 40) $display("FAIL %s rd_valid c=%0d got=%b exp=%b", tag, c, bus.rd_valid, exp_rv); end
            n_cmp++; if (done !== exp_done) begin n_bad++; if (n_bad <= 40) $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, done, exp_done); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; if (n_bad <= 40) $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, busy, exp_busy); end
            if (exp_issue) begin
                n_cmp++; if (bus.raddr !== 10'(c - rd_start)) begin n_bad++; if (n_bad <= 40) $display("FAIL %s raddr c=%0d got=%0d exp=%0d", tag, c, bus.raddr, c - rd_start); end
            end else if (rd_start >= 0 && c == rd_start + pix) begin
                n_cmp++; if (bus.raddr !== 10'd0) begin n_bad++; if (n_bad <= 40) $display("FAIL %s raddr_wrap c=%0d got=%0d exp=0", tag, c, bus.raddr); end
            end
            // advance the timeline
            if (in_acc && v) begin
                ff_v[c + 4] = 1'b1;
                ff_t[c + 4] = (p == 0);
                b++;
                if (b == pix) begin complete = 1'b1; last_beat = c; end
            end
            if (in_acc && !v) stall_exp++;
            if (complete && c == last_beat + 9) begin
                complete = 1'b0;
                if (p + 1 < pass) begin p++; b = 0; acc_start = c + 1; end
                else begin rd_start = c + 1; done_at = c + 1 + pix + 2; end
            end
            if (c == done_at) finished = 1'b1;
            if (abort_pass >= 0 && p == abort_pass && b >= 1) begin aborted = 1'b1; finished = 1'b1; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout got=no_done exp=done_within_%0d", tag, budget);
        end else if (aborted) begin
            // mid-ACC reset: one reset edge, then everything must read idle
            rst = 1'b1; bus.src_valid = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            ff_hold = 1'b0;
            @(negedge clk);
            n_cmp++; if ({busy, done, bus.dven, bus.dv_pre4, bus.src_ready, bus.first_flag, bus.rd_valid} !== 7'd0 || bus.raddr !== 10'd0) begin
                n_bad++; $display("FAIL %s after_reset got=%b raddr=%0d exp=0", tag, {busy, done, bus.dven, bus.dv_pre4, bus.src_ready, bus.first_flag, bus.rd_valid}, bus.raddr);
            end
            bus.src_valid = 1'b0;
        end else begin
            @(negedge clk);
            n_cmp++; if ({busy, done, bus.dven, bus.rd_valid} !== 4'd0) begin
                n_bad++; $display("FAIL %s post_done got=%b exp=0000", tag, {busy, done, bus.dven, bus.rd_valid});
            end
`ifdef SUM_RAM_CTRL_STAT_EN
            if (!trivial) begin
                n_cmp++; if (stall_cnt !== 32'(stall_exp)) begin n_bad++; $display("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, stall_exp); end
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_num = 11'd0; pass_num = 8'd0; bus.src_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset busy_done got=%b%b exp=00", busy, done); end
        n_cmp++; if (bus.dven !== 1'b0 || bus.dv_pre4 !== 1'b0 || bus.src_ready !== 1'b0) begin n_bad++; $display("FAIL reset ram_ctl got=%b%b%b exp=000", bus.dven, bus.dv_pre4, bus.src_ready); end
        n_cmp++; if (bus.first_flag !== 1'b0 || bus.rd_valid !== 1'b0 || bus.raddr !== 10'd0) begin n_bad++; $display("FAIL reset rd_side got=%b%b raddr=%0d exp=0", bus.first_flag, bus.rd_valid, bus.raddr); end
        bus.src_valid = 1'b0;
        ff_hold = 1'b0;
    endtask

    task automatic test_basic();
        run_job(4, 3, 0, 1'b0, -1, "basic_4x3");
    endtask

    task automatic test_raw_single();
        run_job(1, 2, 0, 1'b0, -1, "raw_1x2");
    endtask

    task automatic test_toggle();
        run_job(int'($urandom_range(3, 8)), 5, 1, 1'b0, -1, "toggle_x5");
    endtask

    task automatic test_zero_size();
        run_job(0, 3, 0, 1'b0, -1, "zero_pix");
        run_job(5, 0, 0, 1'b0, -1, "zero_pass");
    endtask

    task automatic test_full_row();
        run_job(1024, 1, 0, 1'b0, -1, "full_row");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            run_job(int'($urandom_range(1, 20)), int'($urandom_range(1, 6)), 2, 1'b1, -1, "random");
        end
    endtask

    task automatic test_reset_mid();
        run_job(6, 4, 0, 1'b0, 2, "reset_mid");
        run_job(3, 2, 1, 1'b0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_job(2, 1, 0, 1'b0, -1, "b2b_a");
        run_job(7, 2, 2, 1'b0, -1, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw_single();
        test_toggle();
        test_zero_size();
        test_full_row();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_ram_ctrl.md
Name: sum_ram_ctrl

Overview:
- Sequencer for the pipelined accumulate RAM (`sum_ram`) in `pipeline_acc`.
- Runs `I_pass_num` accumulation passes over a row of `I_pix_num` pixels, then reads the finished sums out.
- Generates `dven`, `dv_pre4`, `first_flag` and `raddr` for the RAM, and a read-valid strobe for downstream.
- Handles the write-pipeline drain so no pass reads an address before the previous pass has written it.

Parameters:
- C_ASIZE, 10, RAM address width; max row length is 2^C_ASIZE pixels.
- C_PSIZE, 8, pass-count width.
- C_WR_DLY, 7, cycles from a `dv_pre4` beat to its RAM write.
- C_FF_DLY, 4, cycles from a `dv_pre4` beat to its adder stage, where `first_flag` is sampled.
- C_RD_LAT, 2, cycles from `O_raddr` to valid `sum_ram` read data.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  reset, synchronous, active-high.
- I_start  in  1  one-cycle start pulse; ignored unless in IDLE.
- I_pix_num  in  C_ASIZE+1  pixels per pass, 0..2^C_ASIZE; sampled at start.
- I_pass_num  in  C_PSIZE  number of passes; sampled at start.
- I_src_valid  in  1  upstream beat available.
- O_src_ready  out  1  controller accepts a beat.
- O_dven  out  1  to `sum_ram` I_dven.
- O_dv_pre4  out  1  to `sum_ram` I_dv_pre4.
- O_first_flag  out  1  to `sum_ram` I_first_flag.
- O_raddr  out  C_ASIZE  to `sum_ram` I_raddr.
- O_rd_valid  out  1  `sum_ram` O_rdata is a valid final sum this cycle.
- O_busy  out  1  high from start until O_done.
- O_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-operation returns to IDLE at the next edge; no further beats are issued.
- IDLE:
  - I_start with I_pix_num==0 or I_pass_num==0 → single-cycle O_done, no RAM activity.
  - Otherwise latch both sizes; pass_cnt=0, pix_cnt=0; go to ACC.
- ACC:
  - O_dven=1, O_src_ready=1.
  - O_dv_pre4 = I_src_valid & O_src_ready, combinational; each such cycle is one beat and increments pix_cnt.
  - The beat where pix_cnt==pix_num-1 moves to DRAIN; O_src_ready=0 from the next cycle.
  - Gaps in I_src_valid stall the pass and are not counted.
- DRAIN:
  - O_dven=1 for exactly C_WR_DLY+1 cycles, so `sum_ram`'s write address survives the last write.
  - Then go to GAP.
- GAP:
  - O_dven=0 for one cycle, clearing `sum_ram`'s read/write counters.
  - pass_cnt increments.
  - If pass_cnt was pass_num-1 go to RD, else ACC with pix_cnt=0.
- O_first_flag: the per-beat tag (pass_cnt==0) delayed C_FF_DLY cycles through a shift register, so it aligns with that beat's adder stage.
  - Between beats it holds the last shifted value.
  - Cleared on reset.
- RD:
  - O_dven=0; O_raddr counts 0..pix_num-1, one address per cycle, no backpressure.
  - O_rd_valid = O_raddr-issue strobe delayed C_RD_LAT cycles.
  - After the last issue, wait C_RD_LAT cycles, then go to DONE.
- DONE: O_done=1 for one cycle, O_busy drops, return to IDLE.
- Counter wrap: pix_cnt uses C_ASIZE+1 bits, so pix_num=2^C_ASIZE is legal; O_raddr wraps to 0 only after the final read.
- I_start during a busy state is ignored; sizes are not re-sampled.

Optional Feature:
- SUM_RAM_CTRL_STAT_EN defined:
  - adds output O_stall_cnt (32 bits), counting ACC cycles with I_src_valid=0;
  - cleared at accepted start, saturates at all-ones, holds after done.
- Undefined: port and logic absent.

Decomposition:
- Shared package `pipeline_acc_pkg`:
  - state encoding (IDLE, ACC, DRAIN, GAP, RD, DONE);
  - C_WR_DLY, C_FF_DLY, C_RD_LAT defaults, shared with `sum_ram`.
- Sub-module: reuse existing `dly` for the first_flag and rd_valid delay lines; no new sub-module.

Test Plan:
- pix_num=4, pass_num=3, src_valid always high, `sum_ram` data=1 per beat:
  - 12 dv_pre4 beats, each DRAIN 8 cycles with dven high, one dven-low GAP between passes;
  - readout gives 4 rd_valid cycles, each sum=3; done pulses once.
- pix_num=1, pass_num=2 (RAW hazard case): read of addr 0 in pass 1 follows its pass-0 write; final sum = 2× input.
- pass_num=5, src_valid toggling 1,0: dv_pre4 only on valid cycles; first_flag high at adder stage only for pass-0 beats; with STAT_EN, O_stall_cnt equals the count of low cycles.
- pix_num=0 start → done the next cycle; dven, dv_pre4 and rd_valid never assert.
- pix_num=1024, pass_num=1: raddr 0..1023 then stops; exactly 1024 rd_valid cycles.
- I_rst asserted mid-ACC of pass 2: next cycle all outputs 0, state IDLE; a fresh start completes correctly.
